// File: rtl/mod_exp_arbiter.sv
// Round-robin scheduler sharing one ladder exp engine between two requesters; optional MOD_EXP_TIMEOUT_EN abort.
// Latency: req handshake -> eng_start 1 cycle, eng_finish -> rsp_valid 1 cycle; >=3 cycles overhead per job.
// Backpressure: one job in flight, req_ready only in IDLE; rsp held until rsp_ready of the granted requester.
`ifndef BITS
`define BITS 64
`endif

module mod_exp_arbiter #(
  parameter int TIMEOUT_CYCLES = 4096,
  parameter int TO_W           = 13
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        req_valid,
  output logic [1:0]        req_ready,
  input  logic [`BITS-1:0]  req0_base_mont,
  input  logic [`BITS-1:0]  req0_exponent,
  input  logic [`BITS-1:0]  req0_N,
  input  logic [`BITS-1:0]  req0_N_prime,
  input  logic [`BITS-1:0]  req0_one_mont,
  input  logic [`BITS-1:0]  req1_base_mont,
  input  logic [`BITS-1:0]  req1_exponent,
  input  logic [`BITS-1:0]  req1_N,
  input  logic [`BITS-1:0]  req1_N_prime,
  input  logic [`BITS-1:0]  req1_one_mont,
  output logic [1:0]        rsp_valid,
  input  logic [1:0]        rsp_ready,
  output logic [`BITS-1:0]  rsp_result,
  output logic              rsp_err,
  output logic              eng_start,
  output logic [`BITS-1:0]  eng_base_mont,
  output logic [`BITS-1:0]  eng_exponent,
  output logic [`BITS-1:0]  eng_N,
  output logic [`BITS-1:0]  eng_N_prime,
  output logic [`BITS-1:0]  eng_one_mont,
  input  logic              eng_finish,
  input  logic [`BITS-1:0]  eng_result,
  output logic              eng_abort
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t            state, state_nxt;
  logic              rr_ptr;
  logic              gnt_id;
  logic              gnt_nxt;
  logic              launch;
  logic              fin_take;
  logic              to_fire;
  logic [`BITS-1:0]  result_q;

  // A lone requester always wins; rr_ptr only breaks ties.
  always_comb begin
    case (req_valid)
      2'b01:   gnt_nxt = 1'b0;
      2'b10:   gnt_nxt = 1'b1;
      default: gnt_nxt = rr_ptr;
    endcase
  end

  always_comb begin
    state_nxt = state;
    req_ready = 2'b00;
    launch    = 1'b0;
    fin_take  = 1'b0;
    case (state)
      IDLE: begin
        if (|req_valid && !rst) begin
          launch             = 1'b1;
          req_ready[gnt_nxt] = 1'b1;
          state_nxt          = ISSUE;
        end
      end
      ISSUE: state_nxt = WAIT;
      WAIT: begin
        if (eng_finish) begin
          fin_take  = 1'b1;
          state_nxt = RESP;
        end else if (to_fire) begin
          state_nxt = RESP;
        end
      end
      RESP: begin
        if (rsp_ready[gnt_id]) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      rr_ptr        <= 1'b0;
      gnt_id        <= 1'b0;
      eng_base_mont <= '0;
      eng_exponent  <= '0;
      eng_N         <= '0;
      eng_N_prime   <= '0;
      eng_one_mont  <= '0;
      result_q      <= '0;
    end else begin
      state <= state_nxt;
      if (launch) begin
        gnt_id        <= gnt_nxt;
        rr_ptr        <= ~gnt_nxt;
        eng_base_mont <= gnt_nxt ? req1_base_mont : req0_base_mont;
        eng_exponent  <= gnt_nxt ? req1_exponent  : req0_exponent;
        eng_N         <= gnt_nxt ? req1_N         : req0_N;
        eng_N_prime   <= gnt_nxt ? req1_N_prime   : req0_N_prime;
        eng_one_mont  <= gnt_nxt ? req1_one_mont  : req0_one_mont;
      end
      if (fin_take) begin
        result_q <= eng_result;
      end else if (to_fire) begin
        result_q <= '0;
      end
    end
  end

  assign eng_start  = (state == ISSUE);
  assign rsp_valid  = (state == RESP) ? (gnt_id ? 2'b10 : 2'b01) : 2'b00;
  assign rsp_result = result_q;

`ifdef MOD_EXP_TIMEOUT_EN
  logic [TO_W-1:0] to_cnt;
  logic            err_q;

  // Cleared while in ISSUE so it reads 0 on the first WAIT cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      to_cnt <= '0;
      err_q  <= 1'b0;
    end else begin
      if (state == ISSUE) begin
        to_cnt <= '0;
      end else if (state == WAIT) begin
        to_cnt <= to_cnt + 1'b1;
      end
      if (fin_take) begin
        err_q <= 1'b0;
      end else if (to_fire) begin
        err_q <= 1'b1;
      end
    end
  end

  // A finish arriving on the timeout cycle takes precedence over the abort.
  assign to_fire   = (state == WAIT) && !eng_finish && (to_cnt == TO_W'(TIMEOUT_CYCLES));
  assign eng_abort = to_fire;
  assign rsp_err   = err_q;
`else
  logic [TO_W-1:0] unused_to_cfg;
  assign unused_to_cfg = TO_W'(TIMEOUT_CYCLES);
  assign to_fire   = 1'b0;
  assign eng_abort = 1'b0;
  assign rsp_err   = 1'b0;
`endif

endmodule

// File: tb/tb_mod_exp_arbiter.sv
// Self-checking bench for mod_exp_arbiter with a latency-programmable engine model.
`ifndef BITS
`define BITS 64
`endif

module tb_mod_exp_arbiter;

  logic              clk = 1'b0;
  logic              rst;
  logic [1:0]        req_valid;
  logic [1:0]        req_ready;
  logic [`BITS-1:0]  req0_base_mont, req0_exponent, req0_N, req0_N_prime, req0_one_mont;
  logic [`BITS-1:0]  req1_base_mont, req1_exponent, req1_N, req1_N_prime, req1_one_mont;
  logic [1:0]        rsp_valid;
  logic [1:0]        rsp_ready;
  logic [`BITS-1:0]  rsp_result;
  logic              rsp_err;
  logic              eng_start;
  logic [`BITS-1:0]  eng_base_mont, eng_exponent, eng_N, eng_N_prime, eng_one_mont;
  logic              eng_finish;
  logic [`BITS-1:0]  eng_result;
  logic              eng_abort;

  int n_checks = 0;
  int n_pass   = 0;

  // engine model controls
  int                eng_lat      = 5;
  bit                eng_never    = 1'b0;
  bit                eng_fixed_en = 1'b0;
  logic [`BITS-1:0]  eng_fixed    = '0;
  logic [`BITS-1:0]  eng_val      = '0;
  int                eng_cnt      = 0;

  // reference model: round-robin preference after reset is requester 0
  bit exp_pri = 1'b0;

  mod_exp_arbiter #(.TIMEOUT_CYCLES(8), .TO_W(13)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req0_base_mont(req0_base_mont), .req1_base_mont(req1_base_mont),
    .req0_exponent(req0_exponent), .req1_exponent(req1_exponent),
    .req0_N(req0_N), .req1_N(req1_N),
    .req0_N_prime(req0_N_prime), .req1_N_prime(req1_N_prime),
    .req0_one_mont(req0_one_mont), .req1_one_mont(req1_one_mont),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_result(rsp_result), .rsp_err(rsp_err),
    .eng_start(eng_start),
    .eng_base_mont(eng_base_mont), .eng_exponent(eng_exponent), .eng_N(eng_N),
    .eng_N_prime(eng_N_prime), .eng_one_mont(eng_one_mont),
    .eng_finish(eng_finish), .eng_result(eng_result), .eng_abort(eng_abort)
  );

  always #5 clk = ~clk;

  function automatic logic [`BITS-1:0] rnd();
    logic [`BITS-1:0] r = '0;
    for (int i = 0; i < `BITS; i += 32) r = (r << 32) | `BITS'($urandom);
    return r;
  endfunction

  function automatic bit pick(input logic [1:0] v, input bit pri);
    if (v == 2'b01) return 1'b0;
    if (v == 2'b10) return 1'b1;
    return pri;
  endfunction

  function automatic logic [1:0] onehot(input bit g);
    return g ? 2'b10 : 2'b01;
  endfunction

  // Engine: finishes eng_lat cycles after the start pulse; result bus carries noise otherwise.
  initial begin
    eng_finish = 1'b0;
    eng_result = '0;
    forever begin
      @(posedge clk); #1;
      eng_finish = 1'b0;
      eng_result = rnd();
      if (rst) begin
        eng_cnt = 0;
      end else if (eng_cnt > 0) begin
        eng_cnt--;
        if (eng_cnt == 0) begin
          eng_finish = 1'b1;
          eng_result = eng_val;
        end
      end
      if (!rst && eng_start) begin
        eng_val = eng_fixed_en ? eng_fixed : rnd();
        eng_cnt = eng_never ? 0 : eng_lat;
      end
    end
  end

  task automatic tick();
    @(posedge clk); #2;
  endtask

  task automatic rand_ops();
    req0_base_mont = rnd(); req0_exponent = rnd(); req0_N = rnd(); req0_N_prime = rnd(); req0_one_mont = rnd();
    req1_base_mont = rnd(); req1_exponent = rnd(); req1_N = rnd(); req1_N_prime = rnd(); req1_one_mont = rnd();
  endtask

  // Called in ISSUE; ticks until rsp_valid rises or budget expires (cyc stays -1).
  task automatic wait_rsp(input int budget, input logic [`BITS-1:0] exp_n, output int cyc,
                          output int fin_at, output int ab_at, output int ab_cnt, output bit ops_ok);
    cyc = -1; fin_at = -1; ab_at = -1; ab_cnt = 0; ops_ok = 1'b1;
    for (int i = 1; i <= budget; i++) begin
      tick();
      if (eng_finish) fin_at = i;
      if (eng_abort) begin ab_at = i; ab_cnt++; end
      if (eng_N !== exp_n || eng_start !== 1'b0) ops_ok = 1'b0;
      if (rsp_valid !== 2'b00) begin cyc = i; break; end
    end
  endtask

  task automatic finish_rsp(input logic [1:0] g);
    rsp_ready = g;
    tick();
    rsp_ready = 2'b00;
  endtask

  task automatic test_reset();
    rst = 1'b1; req_valid = 2'b11; rsp_ready = 2'b00;
    rand_ops();
    tick(); tick();
    n_checks++; if (req_ready !== 2'b00) $display("FAIL rst_req_ready got=%b exp=00", req_ready); else n_pass++;
    n_checks++; if (rsp_valid !== 2'b00) $display("FAIL rst_rsp_valid got=%b exp=00", rsp_valid); else n_pass++;
    n_checks++; if (eng_start !== 1'b0) $display("FAIL rst_eng_start got=%b exp=0", eng_start); else n_pass++;
    n_checks++; if (eng_abort !== 1'b0) $display("FAIL rst_eng_abort got=%b exp=0", eng_abort); else n_pass++;
    n_checks++; if (rsp_err !== 1'b0) $display("FAIL rst_rsp_err got=%b exp=0", rsp_err); else n_pass++;
    n_checks++; if ({eng_base_mont, eng_N, eng_one_mont} !== '0) $display("FAIL rst_eng_ops got=%h exp=0", eng_N); else n_pass++;
    n_checks++; if (rsp_result !== '0) $display("FAIL rst_rsp_result got=%h exp=0", rsp_result); else n_pass++;
    req_valid = 2'b00;
    rst = 1'b0;
    exp_pri = 1'b0;
    tick();
  endtask

  task automatic test_single();
    int cyc, fin_at, ab_at, ab_cnt;
    bit ops_ok;
    eng_fixed_en = 1'b1; eng_fixed = `BITS'(16'h1234); eng_lat = 20;
    rand_ops();
    req_valid = 2'b01; #1;
    n_checks++; if (req_ready !== 2'b01) $display("FAIL single_ready got=%b exp=01", req_ready); else n_pass++;
    exp_pri = 1'b1;
    tick();
    req_valid = 2'b00; #1;
    n_checks++; if (req_ready !== 2'b00) $display("FAIL single_ready_drop got=%b exp=00", req_ready); else n_pass++;
    n_checks++; if (eng_start !== 1'b1) $display("FAIL single_start got=%b exp=1", eng_start); else n_pass++;
    n_checks++;
    if ({eng_base_mont, eng_exponent, eng_N, eng_N_prime, eng_one_mont} !==
        {req0_base_mont, req0_exponent, req0_N, req0_N_prime, req0_one_mont})
      $display("FAIL single_ops got_N=%h exp_N=%h", eng_N, req0_N);
    else n_pass++;
    wait_rsp(100, req0_N, cyc, fin_at, ab_at, ab_cnt, ops_ok);
    n_checks++; if (cyc !== 21) $display("FAIL single_rsp_cycle got=%0d exp=21", cyc); else n_pass++;
    n_checks++; if (cyc !== fin_at + 1) $display("FAIL single_fin_to_rsp got=%0d exp=%0d", cyc, fin_at + 1); else n_pass++;
    n_checks++; if (!ops_ok) $display("FAIL single_ops_stable got=0 exp=1"); else n_pass++;
    n_checks++; if (rsp_valid !== 2'b01) $display("FAIL single_rsp_valid got=%b exp=01", rsp_valid); else n_pass++;
    n_checks++; if (rsp_result !== `BITS'(16'h1234)) $display("FAIL single_result got=%h exp=1234", rsp_result); else n_pass++;
    n_checks++; if (rsp_err !== 1'b0) $display("FAIL single_err got=%b exp=0", rsp_err); else n_pass++;
    finish_rsp(2'b01);
    n_checks++; if (rsp_valid !== 2'b00) $display("FAIL single_rsp_drop got=%b exp=00", rsp_valid); else n_pass++;
    eng_fixed_en = 1'b0;
  endtask

  task automatic test_fairness();
    int cyc, fin_at, ab_at, ab_cnt, w;
    bit ops_ok, g;
    logic [`BITS-1:0] exp_n;
    rst = 1'b1; tick(); rst = 1'b0; exp_pri = 1'b0;
    req_valid = 2'b11;
    for (int j = 0; j < 4; j++) begin
      rand_ops();
      eng_lat = $urandom_range(1, 10);
      w = 0;
      #1;
      while (req_ready === 2'b00 && w < 10) begin tick(); w++; end
      g = pick(req_valid, exp_pri);
      exp_pri = ~g;
      n_checks++; if (req_ready !== onehot(g)) $display("FAIL fair_grant%0d got=%b exp=%b", j, req_ready, onehot(g)); else n_pass++;
      exp_n = g ? req1_N : req0_N;
      tick();
      n_checks++; if (eng_N !== exp_n) $display("FAIL fair_eng_N%0d got=%h exp=%h", j, eng_N, exp_n); else n_pass++;
      wait_rsp(50, exp_n, cyc, fin_at, ab_at, ab_cnt, ops_ok);
      n_checks++; if (cyc < 0 || rsp_valid !== onehot(g)) $display("FAIL fair_rsp_id%0d got=%b exp=%b", j, rsp_valid, onehot(g)); else n_pass++;
      n_checks++; if (rsp_result !== eng_val) $display("FAIL fair_result%0d got=%h exp=%h", j, rsp_result, eng_val); else n_pass++;
      rsp_ready = onehot(g); #1;
      n_checks++; if (req_ready !== 2'b00) $display("FAIL fair_no_grant_in_rsp%0d got=%b exp=00", j, req_ready); else n_pass++;
      tick();
      rsp_ready = 2'b00;
    end
    req_valid = 2'b00;
    tick();
  endtask

  task automatic test_hold();
    int cyc, fin_at, ab_at, ab_cnt;
    bit ops_ok, stable_ok, quiet_ok, g;
    logic [1:0] v0;
    logic [`BITS-1:0] r0;
    rand_ops();
    eng_lat = 5;
    req_valid = 2'b10; #1;
    g = pick(req_valid, exp_pri);
    exp_pri = ~g;
    n_checks++; if (req_ready !== onehot(g)) $display("FAIL hold_grant got=%b exp=%b", req_ready, onehot(g)); else n_pass++;
    tick();
    req_valid = 2'b00;
    wait_rsp(50, req1_N, cyc, fin_at, ab_at, ab_cnt, ops_ok);
    n_checks++; if (cyc < 0) $display("FAIL hold_rsp_timeout got=%0d exp=6", cyc); else n_pass++;
    v0 = rsp_valid; r0 = rsp_result;
    stable_ok = 1'b1; quiet_ok = 1'b1;
    rsp_ready = ~onehot(g);
    req_valid = 2'b11;
    for (int k = 0; k < 5; k++) begin
      #1;
      if (req_ready !== 2'b00 || eng_start !== 1'b0) quiet_ok = 1'b0;
      tick();
      if (rsp_valid !== onehot(g) || rsp_result !== r0) stable_ok = 1'b0;
    end
    n_checks++; if (!stable_ok) $display("FAIL hold_stable got=%b/%h exp=%b/%h", rsp_valid, rsp_result, onehot(g), r0); else n_pass++;
    n_checks++; if (!quiet_ok) $display("FAIL hold_quiet got=0 exp=1"); else n_pass++;
    n_checks++; if (r0 !== eng_val) $display("FAIL hold_result got=%h exp=%h", r0, eng_val); else n_pass++;
    rsp_ready = onehot(g);
    tick();
    rsp_ready = 2'b00;
    n_checks++; if (rsp_valid !== 2'b00) $display("FAIL hold_rsp_drop got=%b exp=00", rsp_valid); else n_pass++;
    n_checks++; if (req_ready !== onehot(exp_pri)) $display("FAIL hold_idle_grant got=%b exp=%b", req_ready, onehot(exp_pri)); else n_pass++;
    req_valid = 2'b00;
    tick();
  endtask

  task automatic test_rst_wait();
    int cyc, fin_at, ab_at, ab_cnt;
    bit ops_ok;
    rand_ops();
    eng_lat = 30;
    req_valid = 2'b01;
    tick();
    req_valid = 2'b00;
    tick(); tick(); tick();
    rst = 1'b1;
    tick();
    n_checks++; if (rsp_valid !== 2'b00 || req_ready !== 2'b00) $display("FAIL rstw_valid_ready got=%b/%b exp=00/00", rsp_valid, req_ready); else n_pass++;
    n_checks++; if (eng_start !== 1'b0 || eng_abort !== 1'b0 || rsp_err !== 1'b0) $display("FAIL rstw_ctrl got=%b%b%b exp=000", eng_start, eng_abort, rsp_err); else n_pass++;
    n_checks++; if ({eng_N, eng_exponent} !== '0) $display("FAIL rstw_ops got=%h exp=0", eng_N); else n_pass++;
    n_checks++; if (rsp_result !== '0) $display("FAIL rstw_result got=%h exp=0", rsp_result); else n_pass++;
    rst = 1'b0;
    exp_pri = 1'b0;
    rand_ops();
    eng_lat = $urandom_range(2, 8);
    req_valid = 2'b10; #1;
    n_checks++; if (req_ready !== 2'b10) $display("FAIL rstw_regrant got=%b exp=10", req_ready); else n_pass++;
    exp_pri = 1'b0;
    tick();
    req_valid = 2'b00;
    n_checks++; if (eng_start !== 1'b1 || eng_N !== req1_N) $display("FAIL rstw_issue got=%b/%h exp=1/%h", eng_start, eng_N, req1_N); else n_pass++;
    wait_rsp(50, req1_N, cyc, fin_at, ab_at, ab_cnt, ops_ok);
    n_checks++; if (cyc < 0 || rsp_valid !== 2'b10 || rsp_result !== eng_val) $display("FAIL rstw_rsp got=%b/%h exp=10/%h", rsp_valid, rsp_result, eng_val); else n_pass++;
    finish_rsp(2'b10);
  endtask

`ifdef MOD_EXP_TIMEOUT_EN
  task automatic test_timeout();
    int cyc, fin_at, ab_at, ab_cnt;
    bit ops_ok;
    rand_ops();
    eng_never = 1'b1;
    req_valid = 2'b01;
    tick();
    req_valid = 2'b00;
    wait_rsp(40, req0_N, cyc, fin_at, ab_at, ab_cnt, ops_ok);
    n_checks++; if (ab_at !== 9 || ab_cnt !== 1) $display("FAIL to_abort got=%0d/%0d exp=9/1", ab_at, ab_cnt); else n_pass++;
    n_checks++; if (cyc !== 10 || rsp_valid !== 2'b01) $display("FAIL to_rsp got=%0d/%b exp=10/01", cyc, rsp_valid); else n_pass++;
    n_checks++; if (rsp_err !== 1'b1 || rsp_result !== '0) $display("FAIL to_err got=%b/%h exp=1/0", rsp_err, rsp_result); else n_pass++;
    finish_rsp(2'b01);
    eng_never = 1'b0;
  endtask

  task automatic test_timeout_race();
    int cyc, fin_at, ab_at, ab_cnt;
    bit ops_ok;
    rand_ops();
    eng_lat = 9;
    req_valid = 2'b10;
    tick();
    req_valid = 2'b00;
    wait_rsp(40, req1_N, cyc, fin_at, ab_at, ab_cnt, ops_ok);
    n_checks++; if (ab_cnt !== 0 || fin_at !== 9) $display("FAIL race_abort got=%0d/%0d exp=0/9", ab_cnt, fin_at); else n_pass++;
    n_checks++; if (rsp_err !== 1'b0 || rsp_result !== eng_val) $display("FAIL race_result got=%b/%h exp=0/%h", rsp_err, rsp_result, eng_val); else n_pass++;
    finish_rsp(2'b10);
  endtask
`endif

  initial begin
    rst = 1'b1; req_valid = 2'b00; rsp_ready = 2'b00;
    rand_ops();
    test_reset();
    test_single();
    test_fairness();
    test_hold();
    test_rst_wait();
`ifdef MOD_EXP_TIMEOUT_EN
    test_timeout();
    test_timeout_race();
`endif
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
